// File: rtl/input_mapper.sv
// input_mapper
//   Merges PS/2 keyboard events and per-player joystick words into
//   per-player direction and start outputs. Directions pass through an
//   orientation rotation and optional opposing-direction cancellation.
//   Coin requests from any source become a pulse of at least COIN_MIN
//   cycles, followed by a lockout gap of COIN_MIN cycles.
//
// Ports
//   CLK       system clock, rising edge
//   RESET     asynchronous, active-high reset
//   ps2_key   [10] toggle, [9] pressed, [8:0] scancode (bit 8 = extended)
//   joystick  per-player words, bits R,L,D,U,coin,start1,start2
//   rot       orientation: 0 identity, 1 horz-CW, 2 flip, 3 horz-CCW
//   o_up/o_down/o_left/o_right  mapped directions, one bit per player
//   o_start   start button per player
//   o_coin    stretched coin pulse
//   key_evt   one-cycle strobe per decoded keyboard event
module input_mapper #(
  parameter int          NPLAYERS     = 2,
  parameter logic [15:0] COIN_MIN     = 16'd48000,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [10:0]             ps2_key,
  input  logic [16*NPLAYERS-1:0]  joystick,
  input  logic [1:0]              rot,
  output logic [NPLAYERS-1:0]     o_up,
  output logic [NPLAYERS-1:0]     o_down,
  output logic [NPLAYERS-1:0]     o_left,
  output logic [NPLAYERS-1:0]     o_right,
  output logic [NPLAYERS-1:0]     o_start,
  output logic                    o_coin,
  output logic                    key_evt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, GAP} coin_state_t;

  logic                toggle_q;
  logic                armed;
  logic [3:0]          key_dir;     // {U, D, L, R}
  logic [3:0]          key_start;
  logic                key_coin;

  logic [3:0]          mapped [NPLAYERS];
  logic [NPLAYERS-1:0] nxt_up, nxt_down, nxt_left, nxt_right, nxt_start;
  logic                any_s1, any_s2, raw_coin, coin_q;

  coin_state_t         state, nxt_state;
  logic [15:0]         cnt, nxt_cnt;

  // Rotate a {U,D,L,R} vector, then cancel opposing pairs if enabled.
  function automatic logic [3:0] map_dir(input logic [3:0] d, input logic [1:0] r);
    logic u, dn, l, rt, ou, od, ol, orr;
    {u, dn, l, rt} = d;
    case (r)
      2'd1:    {ou, od, ol, orr} = {l, rt, dn, u};
      2'd2:    {ou, od, ol, orr} = {dn, u, rt, l};
      2'd3:    {ou, od, ol, orr} = {rt, l, u, dn};
      default: {ou, od, ol, orr} = {u, dn, l, rt};
    endcase
    if (SOCD_NEUTRAL) begin
      if (ou && od) begin
        ou = 1'b0;
        od = 1'b0;
      end
      if (ol && orr) begin
        ol  = 1'b0;
        orr = 1'b0;
      end
    end
    return {ou, od, ol, orr};
  endfunction

  // Stage 0: keyboard event detection and key-state latches.
  // The first clock after reset only loads the toggle copy, so a toggle
  // that was already high when reset released is not seen as an event.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      toggle_q  <= 1'b0;
      armed     <= 1'b0;
      key_evt   <= 1'b0;
      key_dir   <= 4'b0;
      key_start <= 4'b0;
      key_coin  <= 1'b0;
    end else begin
      key_evt  <= 1'b0;
      toggle_q <= ps2_key[10];
      if (!armed) begin
        armed <= 1'b1;
      end else if (ps2_key[10] != toggle_q) begin
        key_evt <= 1'b1;
        case (ps2_key[7:0])
          8'h75: key_dir[3] <= ps2_key[9];
          8'h72: key_dir[2] <= ps2_key[9];
          8'h6B: key_dir[1] <= ps2_key[9];
          8'h74: key_dir[0] <= ps2_key[9];
          8'h05: if (!ps2_key[8]) key_start[0] <= ps2_key[9];
          8'h06: if (!ps2_key[8] && NPLAYERS > 1) key_start[1] <= ps2_key[9];
          8'h04: if (!ps2_key[8] && NPLAYERS > 2) key_start[2] <= ps2_key[9];
          8'h0C: if (!ps2_key[8] && NPLAYERS > 3) key_start[3] <= ps2_key[9];
          8'h03: if (!ps2_key[8]) key_coin <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    any_s1   = 1'b0;
    any_s2   = 1'b0;
    raw_coin = key_coin;
    for (int p = 0; p < NPLAYERS; p++) begin
      any_s1   = any_s1   | joystick[16*p+5];
      any_s2   = any_s2   | joystick[16*p+6];
      raw_coin = raw_coin | joystick[16*p+4];
    end
    for (int p = 0; p < NPLAYERS; p++) begin
      // joystick nibble is {U,D,L,R}; only player 0 also sees the keyboard
      mapped[p]    = map_dir(joystick[16*p +: 4] | ((p == 0) ? key_dir : 4'b0), rot);
      nxt_up[p]    = mapped[p][3];
      nxt_down[p]  = mapped[p][2];
      nxt_left[p]  = mapped[p][1];
      nxt_right[p] = mapped[p][0];
      nxt_start[p] = key_start[p] | ((p == 0) ? any_s1 : (p == 1) ? any_s2 : 1'b0);
    end
  end

  // Stage 1: registered player outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      o_up    <= '0;
      o_down  <= '0;
      o_left  <= '0;
      o_right <= '0;
      o_start <= '0;
    end else begin
      o_up    <= nxt_up;
      o_down  <= nxt_down;
      o_left  <= nxt_left;
      o_right <= nxt_right;
      o_start <= nxt_start;
    end
  end

  // Coin stretcher: raw level is registered once so a rising edge is
  // recognised only from IDLE; edges during a pulse or its gap are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      coin_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      coin_q <= raw_coin;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (raw_coin && !coin_q) begin
          nxt_state = ACTIVE;
          nxt_cnt   = COIN_MIN - 16'd1;
        end
      end
      ACTIVE: begin
        if (cnt == 16'd0) begin
          // Minimum width reached: keep high while the request lasts.
          if (raw_coin) begin
            nxt_state = HOLD;
          end else begin
            nxt_state = GAP;
            nxt_cnt   = COIN_MIN - 16'd1;
          end
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      HOLD: begin
        if (!raw_coin) begin
          nxt_state = GAP;
          nxt_cnt   = COIN_MIN - 16'd1;
        end
      end
      default: begin
        if (cnt == 16'd0) nxt_state = IDLE;
        else              nxt_cnt   = cnt - 16'd1;
      end
    endcase
  end

  // Decoded straight from the state register so reset drops it at once.
  assign o_coin = (state == ACTIVE) || (state == HOLD);

endmodule

// File: tb/tb_input_mapper.sv
// tb_input_mapper
//   Directed testbench for input_mapper with NPLAYERS=2, COIN_MIN=4,
//   SOCD_NEUTRAL=1. Expected values are hand-derived constants.
module tb_input_mapper;

  logic        CLK;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  rot;
  logic [1:0]  o_up, o_down, o_left, o_right, o_start;
  logic        o_coin;
  logic        key_evt;

  int n_checks = 0;
  int n_fail   = 0;
  logic tog;

  input_mapper #(
    .NPLAYERS(2),
    .COIN_MIN(16'd4),
    .SOCD_NEUTRAL(1'b1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ps2_key(ps2_key),
    .joystick(joystick),
    .rot(rot),
    .o_up(o_up),
    .o_down(o_down),
    .o_left(o_left),
    .o_right(o_right),
    .o_start(o_start),
    .o_coin(o_coin),
    .key_evt(key_evt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  // Drive joystick coin for hold_n cycles, optionally re-raise it at step
  // gap_at for gap_len cycles, and count cycles with o_coin high.
  task automatic coin_run(input int hold_n, input int gap_at, input int gap_len,
                          output int hi);
    hi = 0;
    joystick[4] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (o_coin) hi++;
      if (i == hold_n - 1) joystick[4] = 1'b0;
      if (i == gap_at) joystick[4] = 1'b1;
      if (gap_at >= 0 && i == gap_at + gap_len) joystick[4] = 1'b0;
    end
  endtask

  function automatic logic [3:0] dir0();
    return {o_up[0], o_down[0], o_left[0], o_right[0]};
  endfunction

  initial begin
    int hi;
    RESET    = 1'b1;
    tog      = 1'b1;
    ps2_key  = 11'h400;
    joystick = 32'h0;
    rot      = 2'd0;

    step(2);
    check("reset_outs", {o_up, o_down, o_left, o_right, o_start}, 32'h0);
    check("reset_coin", o_coin, 1'b0);
    check("reset_evt", key_evt, 1'b0);

    @(negedge CLK) RESET = 1'b0;
    step(1);
    check("arm_evt0", key_evt, 1'b0);
    step(2);
    check("arm_evt1", key_evt, 1'b0);
    check("arm_outs", {o_up, o_down, o_left, o_right, o_start}, 32'h0);

    // Unknown scancode still strobes key_evt but changes nothing.
    send_key(1'b1, 9'h000);
    step(1);
    check("unk_evt", key_evt, 1'b1);
    step(1);
    check("unk_evt_clr", key_evt, 1'b0);
    check("unk_outs", {o_up, o_down, o_left, o_right, o_start}, 32'h0);

    send_key(1'b1, 9'h175);
    step(1);
    check("up_evt", key_evt, 1'b1);
    check("up_lat1", o_up, 2'b00);
    step(1);
    check("up_lat2", o_up, 2'b01);
    check("up_evt_clr", key_evt, 1'b0);
    send_key(1'b0, 9'h175);
    step(2);
    check("up_rel", o_up, 2'b00);

    send_key(1'b1, 9'h06B);
    step(2);
    check("kb_left", dir0(), 4'b0010);
    send_key(1'b0, 9'h06B);
    step(2);
    check("kb_left_rel", dir0(), 4'b0000);

    send_key(1'b1, 9'h005);
    step(2);
    check("start1", o_start, 2'b01);
    send_key(1'b1, 9'h004);
    step(1);
    check("start3_evt", key_evt, 1'b1);
    step(1);
    check("start3_ignored", o_start, 2'b01);
    send_key(1'b1, 9'h106);
    step(2);
    check("ext_start2_ignored", o_start, 2'b01);
    send_key(1'b1, 9'h006);
    step(2);
    check("start2", o_start, 2'b11);
    send_key(1'b0, 9'h005);
    step(2);
    send_key(1'b0, 9'h006);
    step(2);
    check("start_rel", o_start, 2'b00);

    // Rotation of joystick U on player 0.
    joystick[3] = 1'b1;
    rot = 2'd1;
    step(1);
    check("rot1_u", dir0(), 4'b0001);
    rot = 2'd3;
    step(1);
    check("rot3_u", dir0(), 4'b0010);
    rot = 2'd2;
    step(1);
    check("rot2_u", dir0(), 4'b0100);
    rot = 2'd0;
    step(1);
    check("rot0_u", dir0(), 4'b1000);

    // Opposing directions cancel.
    joystick[3:0] = 4'b1100;
    step(1);
    check("socd_ud", dir0(), 4'b0000);
    joystick[3:0] = 4'b1011;
    step(1);
    check("socd_lr", dir0(), 4'b1000);
    joystick[3:0] = 4'b0000;

    // Player 1 channel and joystick starts.
    joystick[17] = 1'b1;
    step(1);
    check("p1_left", o_left, 2'b10);
    check("p1_only", o_up | o_down | o_right, 2'b00);
    joystick[17] = 1'b0;
    joystick[21] = 1'b1;
    step(1);
    check("joy_start1", o_start, 2'b01);
    joystick[21] = 1'b0;
    joystick[6]  = 1'b1;
    step(1);
    check("joy_start2", o_start, 2'b10);
    joystick[6] = 1'b0;
    step(3);

    // Coin stretcher.
    coin_run(1, -1, 0, hi);
    check("coin_short", hi, 4);
    coin_run(1, 5, 1, hi);
    check("coin_gap_edge", hi, 4);
    coin_run(1, 5, 10, hi);
    check("coin_gap_level", hi, 4);
    coin_run(10, -1, 0, hi);
    check("coin_hold10", hi, 10);

    // Keyboard coin.
    send_key(1'b1, 9'h003);
    step(2);
    check("kb_coin", o_coin, 1'b1);
    send_key(1'b0, 9'h003);
    step(12);
    check("kb_coin_done", o_coin, 1'b0);

    // Reset in the middle of the pulse.
    joystick[4] = 1'b1;
    step(2);
    check("mid_active", o_coin, 1'b1);
    #1 RESET = 1'b1;
    #1;
    check("reset_async", o_coin, 1'b0);
    joystick[4] = 1'b0;
    @(negedge CLK) RESET = 1'b0;
    step(6);
    check("post_reset_coin", o_coin, 1'b0);
    check("post_reset_evt", key_evt, 1'b0);
    coin_run(1, -1, 0, hi);
    check("post_reset_pulse", hi, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
